// File: rtl/sata_dev_oob_if.sv
// PHY / link-layer signal bundle for the device-side OOB engine.
// slave: the OOB engine itself; master: the PHY and link layer around it.
interface sata_dev_oob_if;
  logic        i_phy_ready;
  logic        i_rx_cominit;
  logic        i_rx_comwake;
  logic        i_rx_elecidle;
  logic        i_rx_valid;
  logic [32:0] i_rx_data;
  logic        o_tx_elecidle;
  logic        o_tx_cominit;
  logic        o_tx_comwake;
  logic        i_tx_comfinish;
  logic        i_tx_primitive;
  logic [31:0] i_tx_data;
  logic        o_tx_ready;
  logic        o_phy_primitive;
  logic [31:0] o_phy_data;
  logic        o_link_up;

  modport slave (
    input  i_phy_ready, i_rx_cominit, i_rx_comwake, i_rx_elecidle,
    input  i_rx_valid, i_rx_data, i_tx_comfinish, i_tx_primitive, i_tx_data,
    output o_tx_elecidle, o_tx_cominit, o_tx_comwake, o_tx_ready,
    output o_phy_primitive, o_phy_data, o_link_up
  );

  modport master (
    output i_phy_ready, i_rx_cominit, i_rx_comwake, i_rx_elecidle,
    output i_rx_valid, i_rx_data, i_tx_comfinish, i_tx_primitive, i_tx_data,
    input  o_tx_elecidle, o_tx_cominit, o_tx_comwake, o_tx_ready,
    input  o_phy_primitive, o_phy_data, o_link_up
  );
endinterface

// File: rtl/sata_dev_oob.sv
// Device-side SATA OOB handshake: answers COMRESET with COMINIT, COMWAKE with
// COMWAKE, then sends ALIGN until the host returns MIN_ALIGNS of them.
// All outputs are registered from the next state, so they change on the same
// edge the state register does.
module sata_dev_oob #(
  parameter real         CLOCK_FREQUENCY_HZ = 75e6,
  parameter int unsigned MIN_ALIGNS         = 3
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  sata_dev_oob_if.slave bus
);

  // ALIGN primitive: K28.5 D10.2 D10.2 D27.3 with the primitive flag set
  localparam logic [32:0] P_ALIGN = {1'b1, 32'hBC4A_4A7B};

  localparam int          TIMEOUT   = $rtoi(873.8e-6 * CLOCK_FREQUENCY_HZ);
  localparam int unsigned CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WD_RELOAD = CW'(TIMEOUT);
  localparam logic [3:0]  MIN_A     = 4'(MIN_ALIGNS);

  typedef enum logic [3:0] {
    DR_RESET          = 4'd0,
    DR_AWAIT_COMRESET = 4'd1,
    DR_AWAIT_CLRRESET = 4'd2,
    DR_ISSUE_COMINIT  = 4'd3,
    DR_AWAIT_COMWAKE  = 4'd4,
    DR_AWAIT_CLRWAKE  = 4'd5,
    DR_ISSUE_COMWAKE  = 4'd6,
    DR_SEND_ALIGN     = 4'd7,
    DR_READY          = 4'd8
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   wd_q, wd_d;
  logic            timeout_q, timeout_d;
  logic [3:0]      align_q, align_d;
  logic            tx_elecidle_q, tx_elecidle_d;
  logic            tx_cominit_q, tx_cominit_d;
  logic            tx_comwake_q, tx_comwake_d;
  logic            link_up_q, link_up_d;
  logic [32:0]     phy_word_q, phy_word_d;
  logic            rx_align;

  assign rx_align = bus.i_rx_valid && (bus.i_rx_data == P_ALIGN);

  // Count consecutive received ALIGNs while sending ALIGN; invalid cycles are ignored
  always_comb begin
    align_d = align_q;
    if (state_q != DR_SEND_ALIGN) begin
      align_d = '0;
    end else if (rx_align) begin
      if (align_q != MIN_A) align_d = align_q + 4'd1;
    end else if (bus.i_rx_valid) begin
      align_d = '0;
    end
  end

  // Next-state logic; phy_ready loss beats the COMRESET override, which beats everything else
  always_comb begin
    state_d = state_q;
    case (state_q)
      DR_RESET:          if (bus.i_phy_ready) state_d = DR_AWAIT_COMRESET;
      DR_AWAIT_COMRESET: if (bus.i_rx_cominit) state_d = DR_AWAIT_CLRRESET;
      DR_AWAIT_CLRRESET: if (!bus.i_rx_cominit) state_d = DR_ISSUE_COMINIT;
      DR_ISSUE_COMINIT:  if (tx_cominit_q && bus.i_tx_comfinish) state_d = DR_AWAIT_COMWAKE;
      DR_AWAIT_COMWAKE: begin
        if (bus.i_rx_comwake)  state_d = DR_AWAIT_CLRWAKE;
        else if (timeout_q)    state_d = DR_ISSUE_COMINIT;
      end
      DR_AWAIT_CLRWAKE:  if (!bus.i_rx_comwake) state_d = DR_ISSUE_COMWAKE;
      DR_ISSUE_COMWAKE:  if (tx_comwake_q && bus.i_tx_comfinish) state_d = DR_SEND_ALIGN;
      DR_SEND_ALIGN: begin
        if (align_d == MIN_A)  state_d = DR_READY;
        else if (timeout_q)    state_d = DR_AWAIT_COMRESET;
      end
      DR_READY:          if (bus.i_rx_elecidle) state_d = DR_AWAIT_COMRESET;
      default:           state_d = DR_RESET;
    endcase
    if (bus.i_rx_cominit && (state_q != DR_RESET) && (state_q != DR_AWAIT_CLRRESET))
      state_d = DR_AWAIT_CLRRESET;
    if (!bus.i_phy_ready)
      state_d = DR_RESET;
  end

  // Watchdog: runs only while resident in AWAIT_COMWAKE or SEND_ALIGN.
  // Reloading on any state change also covers every entry into those states.
  always_comb begin
    if (((state_q != DR_AWAIT_COMWAKE) && (state_q != DR_SEND_ALIGN)) || (state_d != state_q)) begin
      wd_d      = WD_RELOAD;
      timeout_d = 1'b0;
    end else begin
      wd_d      = (wd_q == '0) ? '0 : wd_q - CW'(1);
      timeout_d = (wd_q <= CW'(1));
    end
  end

  // Output values for the state being entered; the PHY word reloads only once ready is up
  always_comb begin
    tx_cominit_d  = (state_d == DR_ISSUE_COMINIT);
    tx_comwake_d  = (state_d == DR_ISSUE_COMWAKE);
    tx_elecidle_d = !((state_d == DR_SEND_ALIGN) || (state_d == DR_READY));
    link_up_d     = (state_d == DR_READY);
    phy_word_d    = P_ALIGN;
    if (state_d == DR_READY)
      phy_word_d = link_up_q ? {bus.i_tx_primitive, bus.i_tx_data} : phy_word_q;
  end

  // State, counters and registered outputs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= DR_RESET;
      wd_q          <= WD_RELOAD;
      timeout_q     <= 1'b0;
      align_q       <= '0;
      tx_elecidle_q <= 1'b1;
      tx_cominit_q  <= 1'b0;
      tx_comwake_q  <= 1'b0;
      link_up_q     <= 1'b0;
      phy_word_q    <= P_ALIGN;
    end else begin
      state_q       <= state_d;
      wd_q          <= wd_d;
      timeout_q     <= timeout_d;
      align_q       <= align_d;
      tx_elecidle_q <= tx_elecidle_d;
      tx_cominit_q  <= tx_cominit_d;
      tx_comwake_q  <= tx_comwake_d;
      link_up_q     <= link_up_d;
      phy_word_q    <= phy_word_d;
    end
  end

  assign bus.o_tx_elecidle   = tx_elecidle_q;
  assign bus.o_tx_cominit    = tx_cominit_q;
  assign bus.o_tx_comwake    = tx_comwake_q;
  assign bus.o_link_up       = link_up_q;
  assign bus.o_tx_ready      = link_up_q;
  assign bus.o_phy_primitive = phy_word_q[32];
  assign bus.o_phy_data      = phy_word_q[31:0];

endmodule

// File: tb/tb_sata_dev_oob.sv
// Bench for sata_dev_oob: scenario tasks drive the host/PHY side and push the
// expected output changes (value + cycle) derived from the handshake timing
// rules; an independent monitor pops them whenever the DUT outputs change.
module tb_sata_dev_oob;
  localparam int unsigned T    = 873;  // 873.8us at 1 MHz, truncated
  localparam int unsigned MINA = 3;
  localparam logic [32:0] ALIGN        = {1'b1, 32'hBC4A_4A7B};
  localparam logic [32:0] ALIGN_NOPRIM = {1'b0, 32'hBC4A_4A7B};
  localparam logic [32:0] SYNC         = {1'b1, 32'hB5B5_957C};
  localparam logic [37:0] RST_VEC      = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ALIGN};

  typedef struct {
    int unsigned at;
    logic [37:0] v;
  } ev_t;

  logic        clk, rst_n;
  int unsigned cyc, total, bad, run;
  ev_t         q[$];
  logic        e_link, e_idle, e_cmi, e_cmw;
  logic [32:0] e_word;
  logic [37:0] last_v;

  sata_dev_oob_if bus();

  sata_dev_oob #(.CLOCK_FREQUENCY_HZ(1.0e6), .MIN_ALIGNS(MINA)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [37:0] sample();
    return {bus.o_link_up, bus.o_tx_ready, bus.o_tx_elecidle, bus.o_tx_cominit,
            bus.o_tx_comwake, bus.o_phy_primitive, bus.o_phy_data};
  endfunction

  function automatic logic [32:0] rand_word();
    logic [32:0] w;
    w = {1'($urandom_range(0, 1)), 32'($urandom)};
    if (w == ALIGN) w[0] = ~w[0];
    return w;
  endfunction

  task automatic push(input int unsigned at);
    logic [37:0] v;
    ev_t e;
    v = {e_link, e_link, e_idle, e_cmi, e_cmw, e_word};
    if (v != last_v) begin
      e.at = at;
      e.v  = v;
      q.push_back(e);
      last_v = v;
    end
  endtask

  task automatic set_defaults();
    e_link = 1'b0; e_idle = 1'b1; e_cmi = 1'b0; e_cmw = 1'b0; e_word = ALIGN;
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_tx(input logic [32:0] w);
    bus.i_tx_primitive = w[32];
    bus.i_tx_data      = w[31:0];
  endtask

  task automatic phy_on();
    bus.i_phy_ready = 1'b1;
    tick(1);
  endtask

  // Host COMRESET of len cycles; COMINIT request rises the cycle after it clears.
  // A comfinish pulse at the start must be ignored (no request is up yet).
  task automatic comreset(input int unsigned len, input bit from_ready);
    int unsigned c;
    c = cyc;
    if (from_ready) begin
      set_defaults();
      push(c + 1);
    end
    bus.i_rx_cominit   = 1'b1;
    bus.i_tx_comfinish = 1'b1;
    tick(1);
    bus.i_tx_comfinish = 1'b0;
    tick(len - 1);
    bus.i_rx_cominit = 1'b0;
    e_cmi = 1'b1;
    push(c + len + 1);
  endtask

  // PHY reports burst finished dly cycles later; the request drops next cycle
  task automatic finish_req(input int unsigned dly, input bit wake);
    int unsigned c;
    tick(dly);
    c = cyc;
    bus.i_tx_comfinish = 1'b1;
    if (wake) begin
      e_cmw = 1'b0;
      e_idle = 1'b0;
    end else begin
      e_cmi = 1'b0;
    end
    push(c + 1);
    tick(1);
    bus.i_tx_comfinish = 1'b0;
  endtask

  task automatic comwake(input int unsigned len);
    int unsigned c;
    c = cyc;
    bus.i_rx_comwake = 1'b1;
    tick(len);
    bus.i_rx_comwake = 1'b0;
    e_cmw = 1'b1;
    push(c + len + 1);
  endtask

  // One received word; link comes up the cycle after the MINA-th consecutive ALIGN
  task automatic rx_word(input logic v, input logic [32:0] w, output bit up);
    bus.i_rx_valid = v;
    bus.i_rx_data  = w;
    up = 1'b0;
    if (v && (w == ALIGN)) run++;
    else if (v) run = 0;
    if (run == MINA) begin
      e_link = 1'b1;
      push(cyc + 1);
      up = 1'b1;
    end
    tick(1);
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic align_phase();
    bit up;
    int unsigned n, k;
    run = 0;
    up  = 1'b0;
    n   = $urandom_range(0, 10);
    for (int unsigned i = 0; i < n && !up; i++) begin
      k = $urandom_range(0, 3);
      case (k)
        0:       rx_word(1'b1, ALIGN, up);
        1:       rx_word(1'b1, rand_word(), up);
        2:       rx_word(1'b0, ALIGN, up);
        default: rx_word(1'b1, ALIGN_NOPRIM, up);
      endcase
    end
    while (!up) rx_word(1'b1, ALIGN, up);
  endtask

  task automatic data_phase(input int unsigned n, input bit deadbeef);
    logic [32:0] w;
    for (int unsigned i = 0; i < n; i++) begin
      w = (deadbeef && i == 0) ? {1'b0, 32'hDEAD_BEEF} : rand_word();
      set_tx(w);
      if (w != e_word) begin
        e_word = w;
        push(cyc + 1);
      end
      tick($urandom_range(1, 3));
    end
  endtask

  task automatic elecidle_exit();
    bus.i_rx_elecidle = 1'b1;
    set_defaults();
    push(cyc + 1);
    tick(1);
    bus.i_rx_elecidle = 1'b0;
    set_tx(ALIGN);
  endtask

  task automatic phy_drop_exit();
    bus.i_phy_ready = 1'b0;
    set_defaults();
    push(cyc + 1);
    tick($urandom_range(1, 4));
    phy_on();
  endtask

  task automatic bring_up(input bit from_ready);
    comreset($urandom_range(1, 6), from_ready);
    finish_req($urandom_range(1, 10), 1'b0);
    comwake($urandom_range(1, 6));
    finish_req($urandom_range(1, 10), 1'b1);
    align_phase();
    data_phase($urandom_range(2, 6), 1'b0);
  endtask

  // Monitor: every change on the outputs must match the next expected event
  initial begin : monitor
    logic [37:0] cur, prev;
    ev_t e;
    @(negedge clk);
    prev = sample();
    total++;
    if (prev !== RST_VEC) begin
      bad++;
      $display("FAIL reset_state: got %h want %h", prev, RST_VEC);
    end
    forever begin
      @(negedge clk);
      cur = sample();
      if (cur !== prev) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change @%0d: got %h prev %h", cyc, cur, prev);
        end else begin
          e = q.pop_front();
          if (cur !== e.v || cyc != e.at) begin
            bad++;
            $display("FAIL output_event: got %h @%0d want %h @%0d", cur, cyc, e.v, e.at);
          end
        end
        prev = cur;
      end
      while (q.size() != 0 && q[0].at < cyc) begin
        e = q.pop_front();
        total++;
        bad++;
        $display("FAIL missed_event: want %h @%0d, now %0d", e.v, e.at, cyc);
      end
    end
  end

  initial begin : stim
    bit up;
    int unsigned c, k, sel;
    bit pend;
    total = 0; bad = 0; run = 0;
    bus.i_phy_ready = 1'b0; bus.i_rx_cominit = 1'b0; bus.i_rx_comwake = 1'b0;
    bus.i_rx_elecidle = 1'b0; bus.i_rx_valid = 1'b0; bus.i_rx_data = '0;
    bus.i_tx_comfinish = 1'b0;
    set_tx(ALIGN);
    set_defaults();
    last_v = RST_VEC;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    // phy not ready: host COMRESET must be ignored
    tick(2);
    bus.i_rx_cominit = 1'b1;
    tick(2);
    bus.i_rx_cominit = 1'b0;
    tick(3);
    phy_on();

    // Nominal handshake with an interrupted ALIGN stream, then DEADBEEF
    comreset(4, 1'b0);
    finish_req(10, 1'b0);
    comwake(4);
    finish_req(3, 1'b1);
    run = 0;
    rx_word(1'b1, ALIGN, up);
    rx_word(1'b1, ALIGN, up);
    rx_word(1'b1, SYNC, up);
    rx_word(1'b1, ALIGN, up);
    rx_word(1'b1, ALIGN, up);
    rx_word(1'b1, ALIGN, up);
    data_phase(6, 1'b1);
    elecidle_exit();

    // No host COMWAKE: COMINIT re-issued T+1 cycles after entering AWAIT_COMWAKE
    comreset($urandom_range(1, 6), 1'b0);
    finish_req($urandom_range(1, 10), 1'b0);
    e_cmi = 1'b1;
    push(cyc + T + 1);
    tick(T + 1);
    finish_req($urandom_range(1, 10), 1'b0);
    comwake($urandom_range(1, 6));
    finish_req($urandom_range(1, 10), 1'b1);
    align_phase();
    data_phase(3, 1'b0);

    // Unsolicited COMRESET in READY, then no ALIGN from host: back to AWAIT_COMRESET
    comreset(5, 1'b1);
    finish_req($urandom_range(1, 10), 1'b0);
    comwake($urandom_range(1, 6));
    finish_req($urandom_range(1, 10), 1'b1);
    c = cyc;
    k = $urandom_range(2, 8);
    run = 0;
    for (int unsigned i = 0; i < k; i++) begin
      if (i[0]) rx_word(1'b1, rand_word(), up);
      else      rx_word(1'b0, ALIGN, up);
    end
    e_idle = 1'b1;
    push(c + T + 1);
    tick(T + 1 - k);
    comreset($urandom_range(1, 6), 1'b0);
    finish_req($urandom_range(1, 10), 1'b0);
    comwake($urandom_range(1, 6));
    finish_req($urandom_range(1, 10), 1'b1);
    align_phase();
    data_phase(3, 1'b0);
    phy_drop_exit();

    // Random bring-ups with random ways out of READY
    pend = 1'b0;
    for (int unsigned it = 0; it < 5; it++) begin
      bring_up(pend);
      pend = 1'b0;
      sel = $urandom_range(0, 2);
      case (sel)
        0:       elecidle_exit();
        1:       pend = 1'b1;
        default: phy_drop_exit();
      endcase
    end

    // Asynchronous reset while COMWAKE is being requested
    comreset($urandom_range(1, 6), pend);
    finish_req($urandom_range(1, 10), 1'b0);
    comwake($urandom_range(1, 6));
    tick($urandom_range(1, 3));
    set_defaults();
    push(cyc);
    rst_n = 1'b0;
    bus.i_phy_ready = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    bus.i_rx_cominit = 1'b1;
    tick(3);
    bus.i_rx_cominit = 1'b0;
    tick($urandom_range(1, 5));
    phy_on();
    bring_up(1'b0);
    elecidle_exit();

    tick(5);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL pending_events: %0d left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
